// File: rtl/operand_pkg.sv
// Shared definitions for the operand pipeline: the operand mode select encoding.
package operand_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_PB    = 3'b000;
  localparam logic [SEL_W-1:0] SEL_IMM_I = 3'b001;
  localparam logic [SEL_W-1:0] SEL_IMM_S = 3'b010;
  localparam logic [SEL_W-1:0] SEL_IMM_U = 3'b011;
  localparam logic [SEL_W-1:0] SEL_PC    = 3'b100;
  localparam logic [SEL_W-1:0] SEL_IMM_B = 3'b101;
  localparam logic [SEL_W-1:0] SEL_IMM_J = 3'b110;
  localparam logic [SEL_W-1:0] SEL_PC4   = 3'b111;

endpackage

// File: rtl/operand_sel.sv
// Combinational operand formation: picks port B, PC, PC+4 or a sign-extended
// RISC-V style immediate decoded from the instruction word.
module operand_sel
  import operand_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pb,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  operand
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [31:0] imm_u;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Size casts of signed values sign-extend to XLEN; pc+4 simply wraps.
  always_comb begin
    operand = '0;
    case (sel)
      SEL_PB:    operand = pb;
      SEL_IMM_I: operand = XLEN'(imm_i);
      SEL_IMM_S: operand = XLEN'(imm_s);
      SEL_IMM_U: operand = XLEN'(imm_u);
      SEL_PC:    operand = pc;
      SEL_IMM_B: operand = XLEN'(imm_b);
      SEL_IMM_J: operand = XLEN'(imm_j);
      SEL_PC4:   operand = pc + XLEN'(4);
      default:   operand = '0;
    endcase
  end

endmodule

// File: rtl/operand_pipe.sv
// Operand pipeline: forms the selected operand and queues it with its select
// and tag in a small FIFO, giving a registered one-cycle path to the consumer.
module operand_pipe
  import operand_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [31:0]              instr,
  input  logic [XLEN-1:0]          pb,
  input  logic [XLEN-1:0]          pc,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_n,
  output logic [SEL_W-1:0]         out_sel,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side; in_ready depends only on occupancy, never on out_ready, and the head
  // entry holds steady while out_valid is high and out_ready is low.

  logic [XLEN-1:0]  operand;
  logic [XLEN-1:0]  mem_n   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  operand_sel #(.XLEN(XLEN)) u_operand_sel (
    .sel     (sel),
    .instr   (instr),
    .pb      (pb),
    .pc      (pc),
    .operand (operand)
  );

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !reset;
  assign pop       = out_valid && out_ready;

  // Pointers are power-of-two wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_n[wr_ptr]   <= operand;
      mem_sel[wr_ptr] <= sel;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  // Head fields are forced to zero whenever nothing is queued.
  assign out_n   = out_valid ? mem_n[rd_ptr]   : '0;
  assign out_sel = out_valid ? mem_sel[rd_ptr] : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;
  assign count   = count_q;

endmodule

// File: tb/tb_operand_pipe.sv
// Directed bench for operand_pipe: driver tasks push expected entries into a
// queue, and an independent monitor pops and compares every delivered operand.
module tb_operand_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = XLEN + 3 + TAG_W;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pb;
  logic [XLEN-1:0]  pc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_n;
  logic [2:0]       out_sel;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  operand_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .instr     (instr),
    .pb        (pb),
    .pc        (pc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .out_sel   (out_sel),
    .out_tag   (out_tag),
    .count     (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: called at a falling edge, holds one request for one cycle.
  task automatic drive(input logic [2:0] s, input logic [31:0] ins,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                       input logic [TAG_W-1:0] t, input logic [XLEN-1:0] exp_n,
                       input logic exp_acc);
    in_valid = 1'b1;
    sel      = s;
    instr    = ins;
    pb       = b;
    pc       = p;
    in_tag   = t;
    #1;
    check("in_ready", in_ready, exp_acc);
    if (exp_acc) exp_q.push_back({exp_n, s, t});
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sel      = '0;
    instr    = '0;
    pb       = '0;
    pc       = '0;
    in_tag   = '0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got n=0x%0h tag=%0d expected no output", out_n, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("out_n",   out_n,   e[EW-1 -: XLEN]);
          check("out_sel", out_sel, e[TAG_W +: 3]);
          check("out_tag", out_tag, e[TAG_W-1:0]);
        end
      end
    end
  end

  // Operand vectors with hand-computed results
  logic [2:0]      v_sel [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0]     v_ins [8] = '{32'h0, 32'hC0C00093, 32'h700007A3, 32'hEC44F037,
                                 32'h0, 32'h80000063, 32'h800000EF, 32'h0};
  logic [XLEN-1:0] v_pb  [8] = '{32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [XLEN-1:0] v_pc  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h80001000, 32'h0, 32'h0, 32'hFFFFFFFC};
  logic [XLEN-1:0] v_exp [8] = '{32'h12345678, 32'hFFFFFC0C, 32'h0000070F, 32'hEC44F000,
                                 32'h80001000, 32'hFFFFF000, 32'hFFF00000, 32'h00000000};

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("reset_count",     count,     0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_n",     out_n,     0);
    check("reset_out_sel",   out_sel,   0);
    check("reset_out_tag",   out_tag,   0);
    reset = 1'b0;
    @(negedge clk);

    // Every operand mode, streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(v_sel[i], v_ins[i], v_pb[i], v_pc[i], TAG_W'(i), v_exp[i], 1'b1);
      check("stream_out_valid", out_valid, 1);
      check("stream_count", count, 1);
    end
    idle();
    repeat (2) @(negedge clk);
    check("empty_count", count, 0);
    check("empty_out_valid", out_valid, 0);
    check("empty_out_n", out_n, 0);
    check("empty_out_tag", out_tag, 0);

    // 16 transfers: pointers wrap several times with no bubbles
    for (int i = 0; i < 16; i++) begin
      drive(3'd0, 32'h0, 32'h0000A000 + XLEN'(i), 32'h0, TAG_W'(i), 32'h0000A000 + XLEN'(i), 1'b1);
      check("no_bubble", out_valid, 1);
      check("pushpop_count", count, 1);
    end
    idle();
    repeat (2) @(negedge clk);

    // Fill with consumer stalled; third push must be refused
    out_ready = 1'b0;
    drive(3'd0, 32'h0, 32'h11111111, 32'h0, 4'd1, 32'h11111111, 1'b1);
    drive(3'd4, 32'h0, 32'h0, 32'h22222222, 4'd2, 32'h22222222, 1'b1);
    drive(3'd7, 32'h0, 32'h0, 32'h33333330, 4'd3, 32'h33333334, 1'b0);
    idle();
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_head_tag", out_tag, 1);
    @(negedge clk);
    check("stall_hold_tag", out_tag, 1);
    check("stall_hold_n", out_n, 32'h11111111);
    check("stall_hold_sel", out_sel, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("drained_count", count, 0);

    // Reset while full, with a push on the reset cycle
    out_ready = 1'b0;
    drive(3'd1, 32'hC0C00093, 32'h0, 32'h0, 4'd5, 32'hFFFFFC0C, 1'b1);
    drive(3'd0, 32'h0, 32'h55555555, 32'h0, 4'd6, 32'h55555555, 1'b1);
    check("prereset_count", count, 2);
    in_valid = 1'b1;
    sel      = 3'd0;
    pb       = 32'h77777777;
    in_tag   = 4'd7;
    reset    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    idle();
    check("midreset_count", count, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_n", out_n, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("postreset_count", count, 0);

    // Final report
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_pipe.md
OPERAND_PIPE -- requirements
Module: operand_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the operand width (32 or 64).
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning output FIFO entries (power of two, >= 2).
REQ-003 The module SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried with each operand.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1, meaning the request fields are valid.
REQ-007 The module SHALL have port in_ready, output, 1, meaning a request is accepted this cycle if in_valid.
REQ-008 The module SHALL have port sel, input, 3, the operand mode select.
REQ-009 The module SHALL have port instr, input, 32, the instruction word the immediates are extracted from.
REQ-010 The module SHALL have port pb, input, XLEN, the register-file port B value.
REQ-011 The module SHALL have port pc, input, XLEN, the instruction address.
REQ-012 The module SHALL have port in_tag, input, TAG_W, opaque sideband.
REQ-013 The module SHALL have port out_valid, output, 1, meaning the head operand is valid.
REQ-014 The module SHALL have port out_ready, input, 1, meaning the consumer takes the head this cycle.
REQ-015 The module SHALL have ports out_n (XLEN), out_sel (3) and out_tag (TAG_W), outputs carrying the head entry.
REQ-016 The module SHALL have port count, output, $clog2(DEPTH)+1, the current FIFO occupancy.

Function
REQ-017 Operand selection SHALL be: 000 pb; 001 sext(instr[31:20]); 010 sext({instr[31:25],instr[11:7]}); 011 sext({instr[31:12],12'b0}).
REQ-018 Operand selection SHALL continue: 100 pc; 101 sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); 110 sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); 111 pc+4.
REQ-019 Sign extension SHALL be to XLEN; pc+4 SHALL wrap modulo 2^XLEN with no carry-out.
REQ-020 A push SHALL occur when in_valid && in_ready; the computed operand, sel and in_tag are written at the tail.
REQ-021 A pop SHALL occur when out_valid && out_ready; the head advances.
REQ-022 Latency SHALL be one cycle: an entry pushed into an empty FIFO is presented with out_valid=1 the next cycle; no combinational input-to-output path exists.
REQ-023 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready.
REQ-024 out_valid SHALL equal (count != 0).
REQ-025 While out_valid && !out_ready, out_n, out_sel and out_tag SHALL hold stable.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and preserve order, including when count==DEPTH-1 or count==1.
REQ-027 When full, in_valid SHALL be ignored; when empty, out_ready SHALL be ignored; count SHALL never exceed DEPTH or underflow.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 When out_valid==0, out_n, out_sel and out_tag SHALL read as zero.

Reset
REQ-030 On reset, count, pointers, out_n, out_sel and out_tag SHALL clear to 0, out_valid to 0, and in_ready to 1 in the following cycle.
REQ-031 Reset mid-operation SHALL discard all entries, and a push coinciding with reset SHALL be dropped.

Structure
REQ-032 Shared package operand_pkg SHALL hold the sel encoding constants (SEL_PB, SEL_IMM_I, SEL_IMM_S, SEL_IMM_U, SEL_PC, SEL_IMM_B, SEL_IMM_J, SEL_PC4).
REQ-033 Combinational operand formation SHALL live in sub-module operand_sel; operand_pipe SHALL instantiate it and own the FIFO.

Verification
REQ-034 XLEN=32, sel=001, instr=0xC0C00093 -> out_n=0xFFFFFC0C one cycle after accept.
REQ-035 sel=010, instr=0x700007A3 -> 0x0000070F; sel=011, instr=0xEC44F037 -> 0xEC44F000.
REQ-036 sel=101, instr=0x80000063 -> 0xFFFFF000; sel=110, instr=0x800000EF -> 0xFFF00000; sel=111, pc=0xFFFFFFFC -> 0x00000000.
REQ-037 DEPTH=2, out_ready=0, three pushes tagged 1,2,3 -> count=2, in_ready=0, tag 3 dropped; then out_ready=1 -> tags 1,2 in order.
REQ-038 count=1, push and pop in the same cycle -> count stays 1; 16 back-to-back transfers with out_ready=1 -> no bubbles after the first, pointers wrap.
REQ-039 count=2, reset pulsed one cycle with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, out_n=0.
